booth4_mult_arbiter: RTL and testbench

Round-robin scheduler that shares one `booth4_multiplier` instance between NREQ independent requesters. It accepts operand pairs over a valid/ready handshake and sequences the multiplier's start/done protocol. It returns each product to the originating requester as a one-cycle response pulse. A watchdog flags a multiplier that never completes.

---
 rtl/booth4_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/booth4_mult_arbiter.sv | 152 +++++++++++++++
 tb/tb_booth4_mult_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/booth4_pkg.sv
// Shared definitions for the booth4 multiplier arbiter.
//   state_e     : arbiter FSM states
//   W_DEF       : default operand width
//   TIMEOUT_DEF : default watchdog limit in WAIT cycles
//   clog2       : ceiling log2, never below 1 so a counter or index always has a bit
package booth4_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  localparam int unsigned W_DEF       = 8;
  localparam int unsigned TIMEOUT_DEF = 64;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < v) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req_i     : request vector
//   ptr_i     : highest-priority index (search starts here and wraps)
//   gnt_o     : one-hot grant, zero when no request
//   gnt_idx_o : binary index of the grant, zero when no request
module rr_arbiter
  import booth4_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   gnt_idx_o
);

  always_comb begin
    logic          found;
    int unsigned   idx;
    logic [IW-1:0] idx_w;
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx   = (32'(ptr_i) + off) % NREQ;
      idx_w = IW'(idx);
      if (!found && req_i[idx_w]) begin
        gnt_o[idx_w] = 1'b1;
        gnt_idx_o    = idx_w;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/booth4_mult_arbiter.sv
// Round-robin scheduler sharing one external booth4 multiplier between NREQ requesters.
//   clk_i, rst_ni               : clock, synchronous active-low reset
//   req_valid_i/req_ready_o     : per-requester handshake (ready is combinational, one-hot)
//   req_a_i, req_b_i            : packed operands, requester i at [i*W +: W]
//   rsp_valid_o                 : one-cycle one-hot response pulse to the originator
//   rsp_product_o, rsp_err_o    : result and timeout flag, valid with rsp_valid_o
//   busy_o                      : high whenever the FSM is not idle
//   mul_start_o, mul_a_o/b_o    : multiplier start pulse and operands
//   mul_done_i, mul_product_i   : multiplier completion and result
module booth4_mult_arbiter
  import booth4_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned W       = W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NREQ-1:0]   req_valid_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic [NREQ*W-1:0] req_a_i,
  input  logic [NREQ*W-1:0] req_b_i,
  output logic [NREQ-1:0]   rsp_valid_o,
  output logic [2*W-1:0]    rsp_product_o,
  output logic              rsp_err_o,
  output logic              busy_o,
  output logic              mul_start_o,
  output logic [W-1:0]      mul_a_o,
  output logic [W-1:0]      mul_b_o,
  input  logic              mul_done_i,
  input  logic [2*W-1:0]    mul_product_i
);

  localparam int unsigned IW = clog2(NREQ);
  localparam int unsigned CW = clog2(TIMEOUT);

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    mul_a_q, mul_a_d;
  logic [W-1:0]    mul_b_q, mul_b_d;
  logic            mul_start_q, mul_start_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [2*W-1:0]  rsp_product_q, rsp_product_d;
  logic            rsp_err_q, rsp_err_d;
  logic            busy_q, busy_d;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr_arbiter (
    .req_i    (req_valid_i),
    .ptr_i    (ptr_q),
    .gnt_o    (gnt),
    .gnt_idx_o(gnt_idx)
  );

  // Accept only in IDLE; the handshake completes in the same cycle.
  assign req_ready_o = (state_q == StIdle) ? gnt : '0;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    cnt_d         = cnt_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    mul_start_d   = 1'b0;
    rsp_valid_d   = '0;
    rsp_product_d = rsp_product_q;
    rsp_err_d     = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (|req_valid_i) begin
          grant_d     = gnt_idx;
          mul_a_d     = req_a_i[32'(gnt_idx)*W +: W];
          mul_b_d     = req_b_i[32'(gnt_idx)*W +: W];
          mul_start_d = 1'b1;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // A done arriving on the last allowed cycle still counts as a completion.
        if (mul_done_i) begin
          rsp_product_d        = mul_product_i;
          rsp_err_d            = 1'b0;
          rsp_valid_d[grant_q] = 1'b1;
          state_d              = StResp;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_product_d        = '0;
          rsp_err_d            = 1'b1;
          rsp_valid_d[grant_q] = 1'b1;
          state_d              = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        ptr_d   = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      grant_q       <= '0;
      cnt_q         <= '0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      mul_start_q   <= 1'b0;
      rsp_valid_q   <= '0;
      rsp_product_q <= '0;
      rsp_err_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      cnt_q         <= cnt_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      mul_start_q   <= mul_start_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_product_q <= rsp_product_d;
      rsp_err_q     <= rsp_err_d;
      busy_q        <= busy_d;
    end
  end

  assign mul_start_o   = mul_start_q;
  assign mul_a_o       = mul_a_q;
  assign mul_b_o       = mul_b_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_product_o = rsp_product_q;
  assign rsp_err_o     = rsp_err_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_booth4_mult_arbiter.sv
// Directed bench for booth4_mult_arbiter; the multiplier is played by the stimulus itself.
module tb_booth4_mult_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 8;
  localparam int unsigned TO   = 8;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   rsp_valid;
  logic [2*W-1:0]    rsp_product;
  logic              rsp_err;
  logic              busy;
  logic              mul_start;
  logic [W-1:0]      mul_a;
  logic [W-1:0]      mul_b;
  logic              mul_done;
  logic [2*W-1:0]    mul_product;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  booth4_mult_arbiter #(
    .NREQ   (NREQ),
    .W      (W),
    .TIMEOUT(TO)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .rsp_valid_o  (rsp_valid),
    .rsp_product_o(rsp_product),
    .rsp_err_o    (rsp_err),
    .busy_o       (busy),
    .mul_start_o  (mul_start),
    .mul_a_o      (mul_a),
    .mul_b_o      (mul_b),
    .mul_done_i   (mul_done),
    .mul_product_i(mul_product)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".ready"}, 32'(req_ready), 32'h0);
    check_eq({tag, ".rsp_valid"}, 32'(rsp_valid), 32'h0);
    check_eq({tag, ".rsp_product"}, 32'(rsp_product), 32'h0);
    check_eq({tag, ".rsp_err"}, 32'(rsp_err), 32'h0);
    check_eq({tag, ".busy"}, 32'(busy), 32'h0);
    check_eq({tag, ".mul_start"}, 32'(mul_start), 32'h0);
    check_eq({tag, ".mul_a"}, 32'(mul_a), 32'h0);
    check_eq({tag, ".mul_b"}, 32'(mul_b), 32'h0);
  endtask

  // Called in an IDLE cycle with req_valid already set. k = WAIT cycles before done;
  // with done=0 pass k=TO to let the watchdog fire.
  task automatic op(input string tag, input int g, input logic [W-1:0] a,
                    input logic [W-1:0] b, input int k, input bit done,
                    input logic [2*W-1:0] p, input logic [2*W-1:0] exp_p,
                    input bit exp_err, input bit drop);
    #1;
    check_eq({tag, ".ready"}, 32'(req_ready), 32'd1 << g);
    tick();
    if (drop) req_valid[g] = 1'b0;
    check_eq({tag, ".start"}, 32'(mul_start), 32'h1);
    check_eq({tag, ".mul_a"}, 32'(mul_a), 32'(a));
    check_eq({tag, ".mul_b"}, 32'(mul_b), 32'(b));
    check_eq({tag, ".busy"}, 32'(busy), 32'h1);
    check_eq({tag, ".ready_issue"}, 32'(req_ready), 32'h0);
    tick();
    check_eq({tag, ".start_low"}, 32'(mul_start), 32'h0);
    repeat (k) tick();
    if (done) begin
      mul_done    = 1'b1;
      mul_product = p;
      tick();
      mul_done    = 1'b0;
      mul_product = '0;
    end
    check_eq({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1 << g);
    check_eq({tag, ".rsp_product"}, 32'(rsp_product), 32'(exp_p));
    check_eq({tag, ".rsp_err"}, 32'(rsp_err), 32'(exp_err));
    tick();
    check_eq({tag, ".rsp_pulse"}, 32'(rsp_valid), 32'h0);
    check_eq({tag, ".idle"}, 32'(busy), 32'h0);
  endtask

  initial begin
    rst_ni      = 1'b0;
    req_valid   = '0;
    req_a       = '0;
    req_b       = '0;
    mul_done    = 1'b0;
    mul_product = '0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_ni = 1'b1;

    // All four valid, operands (i+1, 5): served 0,1,2,3.
    for (int i = 0; i < 4; i++) set_ops(i, W'(i + 1), 8'd5);
    req_valid = 4'b1111;
    op("all0", 0, 8'd1, 8'd5, 2, 1'b1, 16'd5, 16'd5, 1'b0, 1'b1);
    op("all1", 1, 8'd2, 8'd5, 1, 1'b1, 16'd10, 16'd10, 1'b0, 1'b1);
    op("all2", 2, 8'd3, 8'd5, 0, 1'b1, 16'd15, 16'd15, 1'b0, 1'b1);
    op("all3", 3, 8'd4, 8'd5, 3, 1'b1, 16'd20, 16'd20, 1'b0, 1'b1);

    // Requesters 1 and 3 held valid: strict alternation.
    req_valid = 4'b1010;
    op("rr_a", 1, 8'd2, 8'd5, 1, 1'b1, 16'd10, 16'd10, 1'b0, 1'b0);
    op("rr_b", 3, 8'd4, 8'd5, 1, 1'b1, 16'd20, 16'd20, 1'b0, 1'b0);
    op("rr_c", 1, 8'd2, 8'd5, 1, 1'b1, 16'd10, 16'd10, 1'b0, 1'b0);
    op("rr_d", 3, 8'd4, 8'd5, 1, 1'b1, 16'd20, 16'd20, 1'b0, 1'b1);
    req_valid = '0;

    // Single request from 2: 3 * -2 = -6.
    set_ops(2, 8'd3, 8'hFE);
    req_valid = 4'b0100;
    op("single", 2, 8'd3, 8'hFE, 0, 1'b1, 16'hFFFA, 16'hFFFA, 1'b0, 1'b1);

    // Watchdog: no done, response TO+2 cycles after accept.
    set_ops(0, 8'd7, 8'd9);
    req_valid = 4'b0001;
    op("tmo", 0, 8'd7, 8'd9, TO, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1);
    set_ops(3, 8'hFD, 8'd4);
    req_valid = 4'b1000;
    op("post_tmo", 3, 8'hFD, 8'd4, 2, 1'b1, 16'hFFF4, 16'hFFF4, 1'b0, 1'b1);
    set_ops(1, 8'd6, 8'd7);
    req_valid = 4'b0010;
    op("ptr2", 1, 8'd6, 8'd7, 1, 1'b1, 16'h002A, 16'h002A, 1'b0, 1'b1);

    // Reset mid-WAIT: no response, pointer back to 0.
    set_ops(2, 8'd1, 8'd1);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    tick();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    check_reset_outputs("rst_wait");
    tick();
    check_eq("rst_wait.no_rsp", 32'(rsp_valid), 32'h0);
    set_ops(0, 8'd2, 8'hFF);
    set_ops(3, 8'd9, 8'd9);
    req_valid = 4'b1001;
    op("rst_next", 0, 8'd2, 8'hFF, 1, 1'b1, 16'hFFFE, 16'hFFFE, 1'b0, 1'b1);
    req_valid = '0;

    // Stray done in IDLE is ignored.
    mul_done    = 1'b1;
    mul_product = 16'h1234;
    tick();
    mul_done    = 1'b0;
    mul_product = '0;
    check_eq("stray.rsp_valid", 32'(rsp_valid), 32'h0);
    check_eq("stray.busy", 32'(busy), 32'h0);
    tick();
    check_eq("stray.rsp_valid2", 32'(rsp_valid), 32'h0);

    // Done on the last allowed WAIT cycle wins over the watchdog: -8 * -8 = 64.
    set_ops(1, 8'hF8, 8'hF8);
    req_valid = 4'b0010;
    op("coinc", 1, 8'hF8, 8'hF8, TO - 1, 1'b1, 16'h0040, 16'h0040, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
